// File: rtl/mm_host_driver.sv
// ----------------------------------------------------------------------------
// mm_host_driver
//
// Host-side driver for the 1.58-bit matrix-multiply tile. One command carries
// a beat count K. The driver pulses the tile reset for one cycle, then streams
// K load beats (four packed ternary weights plus one signed activation) onto
// the tile pins. It waits out the tile pipeline and captures
// 2*COMPUTE_SLICES result bytes from uo_out on consecutive cycles. Finally it
// replays those bytes on a valid/ready stream.
//
// Ports
//   clk, rst          single clock, synchronous active-high reset
//   cmd_valid/ready   command handshake; ready only while idle
//   cmd_len [7:0]     number of load beats K (0..255)
//   s_valid/ready     load-beat stream
//   s_data [15:0]     [15:8] four 2-bit weight codes (slice 0 in [9:8]),
//                     [7:0] signed activation
//   m_valid/ready     result-byte stream
//   m_data [7:0]      result byte: slice 0 low, slice 0 high, slice 1 low, ...
//   busy              high whenever a command is in flight
//   dut_rst_n         tile reset, active-low (registered)
//   dut_ui_in [7:0]   tile weight pins (registered)
//   dut_uio_in [7:0]  tile activation pins (registered)
//   dut_uo_out [7:0]  tile result pins
//
// PIPE_LAT is the number of cycles from the last load beat on the pins to
// the first result byte on uo_out. It must be at least 1.
// ----------------------------------------------------------------------------
module mm_host_driver #(
    parameter int COMPUTE_SLICES = 4,
    parameter int PIPE_LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_len,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        busy,
    output logic        dut_rst_n,
    output logic [7:0]  dut_ui_in,
    output logic [7:0]  dut_uio_in,
    input  logic [7:0]  dut_uo_out
);

    localparam int NBYTES = 2 * COMPUTE_SLICES;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NBYTES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_LOAD    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_EMIT    = 3'd5
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [7:0]        k_reg;
    logic [7:0]        beat_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  ridx_reg;
    logic [IDX_W-1:0]  ridx_next;

    // Capture buffer: plain array with a registered read, so it maps onto
    // distributed or block RAM.
    logic [7:0] buffer [NBYTES];

    logic [7:0] m_data_reg;
    logic       dut_rst_n_reg;
    logic       dut_rst_n_next;
    logic [7:0] ui_reg;
    logic [7:0] ui_next;
    logic [7:0] uio_reg;
    logic [7:0] uio_next;

    logic [7:0] w_remap;
    logic       s_hs;
    logic       m_hs;

    assign s_hs = (state_reg == ST_LOAD) && s_valid;
    assign m_hs = (state_reg == ST_EMIT) && m_ready;

    // ------------------------------------------------------------------
    // Weight code 2'b10 is reserved. The tile would misread it, so it is
    // driven as a zero weight instead.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_remap
            assign w_remap[2*gi +: 2] =
                (s_data[8 + 2*gi +: 2] == 2'b10) ? 2'b00 : s_data[8 + 2*gi +: 2];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_next = (k_reg != 8'd0) ? ST_LOAD : ST_WAIT;
            end
            ST_LOAD: begin
                // k_reg is non-zero here, so k_reg - 1 cannot underflow.
                if (s_hs && (beat_cnt_reg == k_reg - 8'd1)) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // The tile cannot be stalled, so capture runs back to back.
                if (idx_reg == IDX_LAST) begin
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (m_hs && (ridx_reg == IDX_LAST)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic (direct outputs plus next values of pin registers)
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready      = (state_reg == ST_IDLE) && !rst;
        s_ready        = (state_reg == ST_LOAD);
        m_valid        = (state_reg == ST_EMIT);
        busy           = (state_reg != ST_IDLE);
        ui_next        = 8'h00;
        uio_next       = 8'h00;
        // A bubble in LOAD leaves the pins at zero. A zero weight
        // contributes nothing to the accumulators, so the tile never needs
        // to be stalled.
        if (s_hs) begin
            ui_next  = w_remap;
            uio_next = s_data[7:0];
        end
        // The pin register lines up with the state: the tile reset is low
        // exactly during the CLEAR cycle.
        dut_rst_n_next = (state_next != ST_CLEAR);
    end

    // ------------------------------------------------------------------
    // Read index. It is held while the consumer stalls, so m_data stays
    // stable. It stops at the last byte instead of wrapping.
    // ------------------------------------------------------------------
    always_comb begin
        ridx_next = '0;
        if (state_reg == ST_EMIT) begin
            ridx_next = ridx_reg;
            if (m_hs && (ridx_reg != IDX_LAST)) begin
                ridx_next = ridx_reg + IDX_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            k_reg        <= 8'd0;
            beat_cnt_reg <= 8'd0;
            wait_cnt_reg <= '0;
            idx_reg      <= '0;
            ridx_reg     <= '0;
        end else begin
            if ((state_reg == ST_IDLE) && cmd_valid) begin
                k_reg <= cmd_len;
            end

            // The last increment happens on beat K, so K=255 tops out at
            // 255 without wrapping.
            if (state_reg == ST_CLEAR) begin
                beat_cnt_reg <= 8'd0;
            end else if (s_hs) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end

            if ((state_reg == ST_WAIT) && (wait_cnt_reg != WAIT_LAST)) begin
                wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
            end else begin
                wait_cnt_reg <= '0;
            end

            if ((state_reg == ST_CAPTURE) && (idx_reg != IDX_LAST)) begin
                idx_reg <= idx_reg + IDX_W'(1);
            end else begin
                idx_reg <= '0;
            end

            ridx_reg <= ridx_next;
        end
    end

    // ------------------------------------------------------------------
    // Capture buffer write. There is no reset on the storage. A command
    // always fully rewrites it before any byte is emitted, so an
    // interrupted capture can never leak stale data.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst && (state_reg == ST_CAPTURE)) begin
            buffer[idx_reg] <= dut_uo_out;
        end
    end

    // Registered read. It is refreshed every EMIT cycle from the index that
    // will be current next cycle, so the data is ready on the first EMIT
    // cycle and steady during stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_reg <= 8'h00;
        end else if (state_next == ST_EMIT) begin
            m_data_reg <= buffer[ridx_next];
        end
    end

    // ------------------------------------------------------------------
    // Tile pin registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_rst_n_reg <= 1'b0;
            ui_reg        <= 8'h00;
            uio_reg       <= 8'h00;
        end else begin
            dut_rst_n_reg <= dut_rst_n_next;
            ui_reg        <= ui_next;
            uio_reg       <= uio_next;
        end
    end

    assign m_data     = m_data_reg;
    assign dut_rst_n  = dut_rst_n_reg;
    assign dut_ui_in  = ui_reg;
    assign dut_uio_in = uio_reg;

endmodule
